// File: rtl/phase_cmd_pkg.sv
// rtl/phase_cmd_pkg.sv - opcode class decode, timeout tag and FSM encoding shared by the scheduler
package phase_cmd_pkg;
  // Bit positions within the 8-bit opcode field
  localparam int OP_READ_BIT = 7;
  localparam int OP_SYNC_BIT = 6;
  localparam logic [7:0] TIMEOUT_TAG = 8'hEE;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_SYNC  = 3'd1,
    ST_ISSUE      = 3'd2,
    ST_WAIT_REPLY = 3'd3,
    ST_GAP        = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CLS_IMMEDIATE = 2'd0,
    CLS_SYNCED    = 2'd1,
    CLS_READ      = 2'd2
  } cmd_class_e;

  function automatic cmd_class_e cmd_class(input logic [7:0] opcode);
    if (opcode[OP_READ_BIT]) return CLS_READ;
    if (opcode[OP_SYNC_BIT]) return CLS_SYNCED;
    return CLS_IMMEDIATE;
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command FIFO with full/empty/level and a synchronous clear
module cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  input  logic                     i_clear,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign o_full  = (count_q == FULL_LEVEL);
  assign o_empty = (count_q == '0);
  assign o_level = count_q;
  assign o_head  = mem_q[rd_ptr_q];

  // A pop frees the slot this same cycle, so a push into a full FIFO still lands
  assign do_pop  = i_pop && !o_empty && !i_clear;
  assign do_push = i_push && (!o_full || do_pop) && !i_clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_push_data;
  end
endmodule

// File: rtl/phase_cmd_scheduler.sv
// rtl/phase_cmd_scheduler.sv - queues host commands and issues them one at a time to the phase generator
module phase_cmd_scheduler
  import phase_cmd_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int ISSUE_GAP     = 4,
  parameter int REPLY_TIMEOUT = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_command,
  input  logic [23:0]            i_command_data,
  input  logic                   i_flush,
  input  logic                   i_sync,
  input  logic                   i_reply,
  input  logic [23:0]            i_reply_data,
  output logic                   o_command,
  output logic [23:0]            o_command_data,
  output logic                   o_reply,
  output logic [23:0]            o_reply_data,
  output logic                   o_overflow,
  output logic [7:0]             o_drop_count,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_busy
);
  localparam int TW = $clog2(REPLY_TIMEOUT + 1);
  // Pulse spacing is GAP cycles + IDLE + ISSUE, so GAP covers the remainder
  localparam int GAP_CYCLES = (ISSUE_GAP > 3) ? ISSUE_GAP - 2 : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_e         state_q, state_d;
  logic [23:0]    hold_q, hold_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic           sync_q;
  logic           cmd_q, cmd_d, reply_q, reply_d, ovf_q, ovf_d;
  logic [23:0]    cmd_data_q, cmd_data_d, reply_data_q, reply_data_d;
  logic [7:0]     drops_q, drops_d;
  logic [23:0]    fifo_head;
  logic           fifo_full, fifo_empty, fifo_pop, push, drop;

  assign push     = i_command && !i_flush;
  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty && !i_flush;
  assign drop     = push && fifo_full && !fifo_pop;

  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(24)) u_fifo (
    .clk         (i_clk),
    .rst_n       (i_rst_n),
    .i_push      (push),
    .i_push_data (i_command_data),
    .i_pop       (fifo_pop),
    .i_clear     (i_flush),
    .o_head      (fifo_head),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_level     (o_level)
  );

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    timer_d      = timer_q;
    gap_d        = gap_q;
    cmd_d        = 1'b0;
    cmd_data_d   = cmd_data_q;
    reply_d      = 1'b0;
    reply_data_d = reply_data_q;
    ovf_d        = drop;
    drops_d      = drops_q + {7'd0, drop && (drops_q != 8'hFF)};
    // Any real reply is forwarded, solicited or not, and beats a same-cycle timeout
    if (i_reply) begin
      reply_d      = 1'b1;
      reply_data_d = i_reply_data;
    end
    case (state_q)
      ST_IDLE: begin
        if (fifo_pop) begin
          hold_d  = fifo_head;
          state_d = (cmd_class(fifo_head[23:16]) == CLS_SYNCED) ? ST_WAIT_SYNC : ST_ISSUE;
        end
      end
      ST_WAIT_SYNC: begin
        if (i_flush)               state_d = ST_IDLE;
        else if (i_sync && !sync_q) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        cmd_d      = 1'b1;
        cmd_data_d = hold_q;
        if (cmd_class(hold_q[23:16]) == CLS_READ) begin
          timer_d = '0;
          state_d = ST_WAIT_REPLY;
        end else begin
          gap_d   = GW'(GAP_CYCLES - 1);
          state_d = ST_GAP;
        end
      end
      ST_WAIT_REPLY: begin
        if (i_reply) begin
          gap_d   = GW'(GAP_CYCLES - 1);
          state_d = ST_GAP;
        end else if (timer_q == TW'(REPLY_TIMEOUT - 1)) begin
          reply_d      = 1'b1;
          reply_data_d = {TIMEOUT_TAG, hold_q[23:16], 8'h00};
          gap_d        = GW'(GAP_CYCLES - 1);
          state_d      = ST_GAP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      timer_q      <= '0;
      gap_q        <= '0;
      sync_q       <= 1'b0;
      cmd_q        <= 1'b0;
      cmd_data_q   <= '0;
      reply_q      <= 1'b0;
      reply_data_q <= '0;
      ovf_q        <= 1'b0;
      drops_q      <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      timer_q      <= timer_d;
      gap_q        <= gap_d;
      sync_q       <= i_sync;
      cmd_q        <= cmd_d;
      cmd_data_q   <= cmd_data_d;
      reply_q      <= reply_d;
      reply_data_q <= reply_data_d;
      ovf_q        <= ovf_d;
      drops_q      <= drops_d;
    end
  end

  assign o_command      = cmd_q;
  assign o_command_data = cmd_data_q;
  assign o_reply        = reply_q;
  assign o_reply_data   = reply_data_q;
  assign o_overflow     = ovf_q;
  assign o_drop_count   = drops_q;
  assign o_busy         = (state_q != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_phase_cmd_scheduler.sv
// tb/tb_phase_cmd_scheduler.sv - scoreboard bench for phase_cmd_scheduler
module tb_phase_cmd_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_command = 1'b0;
  logic [23:0] i_command_data = '0;
  logic        i_flush = 1'b0;
  logic        i_sync = 1'b0;
  logic        i_reply = 1'b0;
  logic [23:0] i_reply_data = '0;
  logic        o_command, o_reply, o_overflow, o_busy;
  logic [23:0] o_command_data, o_reply_data;
  logic [7:0]  o_drop_count;
  logic [4:0]  o_level;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_cmd[$];
  logic [23:0] exp_rep[$];

  always #5 clk = ~clk;

  phase_cmd_scheduler #(.DEPTH(16), .ISSUE_GAP(4), .REPLY_TIMEOUT(1024)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_command(i_command), .i_command_data(i_command_data),
    .i_flush(i_flush), .i_sync(i_sync), .i_reply(i_reply), .i_reply_data(i_reply_data),
    .o_command(o_command), .o_command_data(o_command_data), .o_reply(o_reply),
    .o_reply_data(o_reply_data), .o_overflow(o_overflow), .o_drop_count(o_drop_count),
    .o_level(o_level), .o_busy(o_busy)
  );

  always @(negedge clk) begin
    logic [23:0] e;
    if (rst_n && o_command) begin
      checks++;
      if (exp_cmd.size() == 0) begin
        errors++;
        $display("FAIL sb_cmd_unexpected: issued %h, required no issue", o_command_data);
      end else begin
        e = exp_cmd.pop_front();
        if (o_command_data !== e) begin
          errors++;
          $display("FAIL sb_cmd_data: got %h, required %h", o_command_data, e);
        end
      end
    end
    if (rst_n && o_reply) begin
      checks++;
      if (exp_rep.size() == 0) begin
        errors++;
        $display("FAIL sb_reply_unexpected: reply %h, required no reply", o_reply_data);
      end else begin
        e = exp_rep.pop_front();
        if (o_reply_data !== e) begin
          errors++;
          $display("FAIL sb_reply_data: got %h, required %h", o_reply_data, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [23:0] d, input bit will_issue);
    i_command = 1'b1;
    i_command_data = d;
    if (will_issue) exp_cmd.push_back(d);
    step();
    i_command = 1'b0;
  endtask

  task automatic wait_cmd(input string name);
    int n = 0;
    while (!o_command && n < 40) begin step(); n++; end
    checks++;
    if (!o_command) begin
      errors++;
      $display("FAIL %s_issue_wait: o_command=%b after %0d cycles, required 1", name, o_command, n);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (o_busy && n < 40) begin step(); n++; end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_wait: o_busy=%b, required 0", name, o_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({o_command, o_reply, o_overflow, o_busy} !== 4'b0 || o_level !== 5'd0) begin
      errors++;
      $display("FAIL reset_flags: cmd/rep/ovf/busy=%b%b%b%b level=%0d, required 0000 level 0",
               o_command, o_reply, o_overflow, o_busy, o_level);
    end
    checks++;
    if (o_command_data !== 24'h0 || o_reply_data !== 24'h0 || o_drop_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_data: cmd=%h rep=%h drops=%0d, required 0/0/0",
               o_command_data, o_reply_data, o_drop_count);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_immediate();
    push(24'h010203, 1'b1);
    checks++;
    if (o_command !== 1'b0) begin errors++; $display("FAIL imm_early_1: o_command=%b, required 0", o_command); end
    step();
    checks++;
    if (o_command !== 1'b0) begin errors++; $display("FAIL imm_early_2: o_command=%b, required 0", o_command); end
    step();
    checks++;
    if (o_command !== 1'b1 || o_command_data !== 24'h010203) begin
      errors++;
      $display("FAIL imm_latency: o_command=%b data=%h, required 1 010203", o_command, o_command_data);
    end
    step();
    checks++;
    if (o_command !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL imm_gap: o_command=%b o_busy=%b, required 0 1", o_command, o_busy);
    end
    step();
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL imm_busy_fall: o_busy=%b, required 0", o_busy); end
  endtask

  task automatic test_overflow_flush();
    int ovf = 0;
    bit seen = 1'b0;
    i_sync = 1'b0;
    push(24'h400000, 1'b0);
    step(); step();
    for (int i = 0; i < 20; i++) begin
      i_command = 1'b1;
      i_command_data = 24'h400100 + 24'(i);
      step();
      ovf += int'(o_overflow);
    end
    i_command = 1'b0;
    step();
    ovf += int'(o_overflow);
    checks++;
    if (ovf != 4) begin errors++; $display("FAIL ovf_pulses: got %0d, required 4", ovf); end
    checks++;
    if (o_drop_count !== 8'd4 || o_level !== 5'd16) begin
      errors++;
      $display("FAIL ovf_counts: drops=%0d level=%0d, required 4 16", o_drop_count, o_level);
    end
    i_flush = 1'b1;
    i_command = 1'b1;
    i_command_data = 24'h400999;
    step();
    i_flush = 1'b0;
    i_command = 1'b0;
    checks++;
    if (o_level !== 5'd0 || o_busy !== 1'b0 || o_drop_count !== 8'd4 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: level=%0d busy=%b drops=%0d ovf=%b, required 0 0 4 0",
               o_level, o_busy, o_drop_count, o_overflow);
    end
    for (int i = 0; i < 12; i++) begin
      i_sync = i[1];
      step();
      seen |= o_command;
    end
    i_sync = 1'b0;
    checks++;
    if (seen) begin errors++; $display("FAIL flush_no_issue: o_command seen=1, required 0"); end
  endtask

  task automatic test_synced();
    bit seen = 1'b0;
    i_sync = 1'b1;
    step();
    push(24'h400055, 1'b1);
    repeat (8) begin step(); seen |= o_command; end
    checks++;
    if (seen) begin errors++; $display("FAIL sync_level_held: o_command seen=1, required 0"); end
    i_sync = 1'b0;
    step(); step();
    i_sync = 1'b1;
    step();
    checks++;
    if (o_command !== 1'b0) begin errors++; $display("FAIL sync_early: o_command=%b, required 0", o_command); end
    step();
    checks++;
    if (o_command !== 1'b1 || o_command_data !== 24'h400055) begin
      errors++;
      $display("FAIL sync_issue: o_command=%b data=%h, required 1 400055", o_command, o_command_data);
    end
    i_sync = 1'b0;
    wait_idle("sync");
  endtask

  task automatic test_read();
    int n = 0;
    push(24'h800000, 1'b1);
    wait_cmd("read");
    repeat (9) step();
    i_reply = 1'b1;
    i_reply_data = 24'hABCDEF;
    exp_rep.push_back(24'hABCDEF);
    step();
    i_reply = 1'b0;
    checks++;
    if (o_reply !== 1'b1 || o_reply_data !== 24'hABCDEF) begin
      errors++;
      $display("FAIL read_reply: o_reply=%b data=%h, required 1 abcdef", o_reply, o_reply_data);
    end
    wait_idle("read");
    push(24'h800000, 1'b1);
    exp_rep.push_back(24'hEE8000);
    wait_cmd("timeout");
    while (!o_reply && n < 1100) begin step(); n++; end
    checks++;
    if (n != 1024 || o_reply_data !== 24'hEE8000) begin
      errors++;
      $display("FAIL read_timeout: after %0d cycles data=%h, required 1024 ee8000", n, o_reply_data);
    end
    wait_idle("timeout");
    push(24'h810000, 1'b1);
    exp_rep.push_back(24'h5A5A5A);
    wait_cmd("race");
    repeat (1023) step();
    i_reply = 1'b1;
    i_reply_data = 24'h5A5A5A;
    step();
    i_reply = 1'b0;
    checks++;
    if (o_reply !== 1'b1 || o_reply_data !== 24'h5A5A5A) begin
      errors++;
      $display("FAIL reply_vs_timeout: o_reply=%b data=%h, required 1 5a5a5a", o_reply, o_reply_data);
    end
    repeat (4) step();
    wait_idle("race");
    i_reply = 1'b1;
    i_reply_data = 24'h123456;
    exp_rep.push_back(24'h123456);
    step();
    i_reply = 1'b0;
    checks++;
    if (o_reply !== 1'b1 || o_reply_data !== 24'h123456) begin
      errors++;
      $display("FAIL unsolicited: o_reply=%b data=%h, required 1 123456", o_reply, o_reply_data);
    end
  endtask

  task automatic test_back_to_back();
    int t[$];
    i_command = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      i_command_data = {3{8'(i)}};
      exp_cmd.push_back({3{8'(i)}});
      step();
    end
    i_command = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (o_command) t.push_back(n);
      step();
    end
    checks++;
    if (t.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d pulses, required 3", t.size());
    end else begin
      checks++;
      if (t[1] - t[0] != 4 || t[2] - t[1] != 4) begin
        errors++;
        $display("FAIL b2b_spacing: got %0d and %0d, required 4 and 4", t[1] - t[0], t[2] - t[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    push(24'h800000, 1'b1);
    wait_cmd("midrst");
    push(24'h020202, 1'b0);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_level !== 5'd0) begin
      errors++;
      $display("FAIL midrst_state: busy=%b level=%0d, required 0 0", o_busy, o_level);
    end
    step(); step();
    rst_n = 1'b1;
    for (int n = 0; n < 1100; n++) begin
      step();
      seen |= (o_reply | o_command);
    end
    checks++;
    if (seen || o_level !== 5'd0 || o_drop_count !== 8'd0) begin
      errors++;
      $display("FAIL midrst_quiet: activity=%b level=%0d drops=%0d, required 0 0 0", seen, o_level, o_drop_count);
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_overflow_flush();
    test_synced();
    test_read();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (exp_cmd.size() != 0 || exp_rep.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d cmds %0d replies pending, required 0 0", exp_cmd.size(), exp_rep.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
